// File: rtl/tile_cmd_if.sv
// Command/completion channel between tile_scheduler and the tile engine.
interface tile_cmd_if #(
  parameter int unsigned PIX_W = 32,
  parameter int unsigned CH_W  = 7
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [PIX_W-1:0] cmd_pix_base;
  logic [PIX_W-1:0] cmd_pix_cnt;
  logic [CH_W-1:0]  cmd_k_base;
  logic [CH_W-1:0]  cmd_k_cnt;
  logic [CH_W-1:0]  cmd_d_base;
  logic [CH_W-1:0]  cmd_d_cnt;
  logic             cmd_first_d;
  logic             cmd_last_d;
  logic             tile_done;

  modport master (
    output cmd_valid, cmd_pix_base, cmd_pix_cnt, cmd_k_base, cmd_k_cnt,
           cmd_d_base, cmd_d_cnt, cmd_first_d, cmd_last_d,
    input  cmd_ready, tile_done
  );

  modport slave (
    input  cmd_valid, cmd_pix_base, cmd_pix_cnt, cmd_k_base, cmd_k_cnt,
           cmd_d_base, cmd_d_cnt, cmd_first_d, cmd_last_d,
    output cmd_ready, tile_done
  );
endinterface

// File: rtl/tile_scheduler.sv
// Walks a layer as pix > k > d tile loops, issuing one command per tile and
// waiting for each tile's completion before issuing the next.
module tile_scheduler #(
  parameter int unsigned PIX_W = 32,
  parameter int unsigned CH_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [PIX_W-1:0] tile_n_i,
  input  logic [PIX_W-1:0] total_pix_i,
  input  logic [CH_W-1:0]  in_c_i,
  input  logic [CH_W-1:0]  out_c_i,
  input  logic [CH_W-1:0]  tile_d_i,
  input  logic [CH_W-1:0]  tile_k_i,
  tile_cmd_if.master       cmd,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StErr, StFin} state_e;

  state_e           state_q, state_d;
  logic [PIX_W-1:0] tile_n_q, tile_n_d, total_pix_q, total_pix_d, pix_base_q, pix_base_d;
  logic [CH_W-1:0]  in_c_q, in_c_d, out_c_q, out_c_d, tile_d_q, tile_d_d, tile_k_q, tile_k_d;
  logic [CH_W-1:0]  k_base_q, k_base_d, d_base_q, d_base_d;
  logic             busy_q, busy_d, err_q, err_d;

  // Remaining extent and clipped tile size per loop; end tests use one extra bit.
  logic [PIX_W-1:0] pix_rem, pix_cnt;
  logic [CH_W-1:0]  k_rem, k_cnt, d_rem, d_cnt;
  logic [PIX_W:0]   pix_next;
  logic [CH_W:0]    k_next, d_next;
  logic             pix_end, k_end, d_end;

  assign pix_rem  = total_pix_q - pix_base_q;
  assign pix_cnt  = (tile_n_q < pix_rem) ? tile_n_q : pix_rem;
  assign pix_next = {1'b0, pix_base_q} + {1'b0, pix_cnt};
  assign pix_end  = pix_next >= {1'b0, total_pix_q};

  assign k_rem    = out_c_q - k_base_q;
  assign k_cnt    = (tile_k_q < k_rem) ? tile_k_q : k_rem;
  assign k_next   = {1'b0, k_base_q} + {1'b0, k_cnt};
  assign k_end    = k_next >= {1'b0, out_c_q};

  assign d_rem    = in_c_q - d_base_q;
  assign d_cnt    = (tile_d_q < d_rem) ? tile_d_q : d_rem;
  assign d_next   = {1'b0, d_base_q} + {1'b0, d_cnt};
  assign d_end    = d_next >= {1'b0, in_c_q};

  always_comb begin
    state_d     = state_q;
    tile_n_d    = tile_n_q;
    total_pix_d = total_pix_q;
    in_c_d      = in_c_q;
    out_c_d     = out_c_q;
    tile_d_d    = tile_d_q;
    tile_k_d    = tile_k_q;
    pix_base_d  = pix_base_q;
    k_base_d    = k_base_q;
    d_base_d    = d_base_q;
    busy_d      = busy_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          tile_n_d    = tile_n_i;
          total_pix_d = total_pix_i;
          in_c_d      = in_c_i;
          out_c_d     = out_c_i;
          tile_d_d    = tile_d_i;
          tile_k_d    = tile_k_i;
          pix_base_d  = '0;
          k_base_d    = '0;
          d_base_d    = '0;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (tile_n_q == '0 || tile_d_q == '0 || tile_k_q == '0) begin
          state_d = StErr;
        end else if (total_pix_q == '0 || out_c_q == '0 || in_c_q == '0) begin
          state_d = StFin;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd.cmd_ready) state_d = StWait;
      end
      StWait: begin
        if (cmd.tile_done) begin
          state_d = StIssue;
          if (!d_end) begin
            d_base_d = d_next[CH_W-1:0];
          end else begin
            d_base_d = '0;
            if (!k_end) begin
              k_base_d = k_next[CH_W-1:0];
            end else begin
              k_base_d = '0;
              if (pix_end) state_d = StFin;
              else         pix_base_d = pix_next[PIX_W-1:0];
            end
          end
        end
      end
      StErr: begin
        err_d   = 1'b1;
        state_d = StFin;
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tile_n_q    <= '0;
      total_pix_q <= '0;
      in_c_q      <= '0;
      out_c_q     <= '0;
      tile_d_q    <= '0;
      tile_k_q    <= '0;
      pix_base_q  <= '0;
      k_base_q    <= '0;
      d_base_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_n_q    <= tile_n_d;
      total_pix_q <= total_pix_d;
      in_c_q      <= in_c_d;
      out_c_q     <= out_c_d;
      tile_d_q    <= tile_d_d;
      tile_k_q    <= tile_k_d;
      pix_base_q  <= pix_base_d;
      k_base_q    <= k_base_d;
      d_base_q    <= d_base_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Command fields are forced to zero outside ISSUE so idle outputs read as 0.
  logic issue;
  assign issue            = (state_q == StIssue);
  assign cmd.cmd_valid    = issue;
  assign cmd.cmd_pix_base = issue ? pix_base_q : '0;
  assign cmd.cmd_pix_cnt  = issue ? pix_cnt : '0;
  assign cmd.cmd_k_base   = issue ? k_base_q : '0;
  assign cmd.cmd_k_cnt    = issue ? k_cnt : '0;
  assign cmd.cmd_d_base   = issue ? d_base_q : '0;
  assign cmd.cmd_d_cnt    = issue ? d_cnt : '0;
  assign cmd.cmd_first_d  = issue && (d_base_q == '0);
  assign cmd.cmd_last_d   = issue && d_end;

  assign busy_o = busy_q;
  assign done_o = (state_q == StFin);
  assign err_o  = err_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: a loop model fills a command scoreboard
// at each start and every issued command is popped and compared.
module tb_tile_scheduler;
  localparam int unsigned PIX_W = 32;
  localparam int unsigned CH_W  = 7;

  typedef struct packed {
    logic [PIX_W-1:0] pb;
    logic [PIX_W-1:0] pc;
    logic [CH_W-1:0]  kb;
    logic [CH_W-1:0]  kc;
    logic [CH_W-1:0]  db;
    logic [CH_W-1:0]  dc;
    logic             fd;
    logic             ld;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [PIX_W-1:0] tile_n = '0, total_pix = '0;
  logic [CH_W-1:0]  in_c = '0, out_c = '0, tile_d = '0, tile_k = '0;
  logic             busy, done, err;

  int   errors = 0;
  int   checks = 0;
  cmd_t sb[$];

  tile_cmd_if #(.PIX_W(PIX_W), .CH_W(CH_W)) tif ();

  tile_scheduler #(.PIX_W(PIX_W), .CH_W(CH_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .tile_n_i    (tile_n),
    .total_pix_i (total_pix),
    .in_c_i      (in_c),
    .out_c_i     (out_c),
    .tile_d_i    (tile_d),
    .tile_k_i    (tile_k),
    .cmd         (tif.master),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t obs_cmd();
    cmd_t c;
    c.pb = tif.cmd_pix_base;
    c.pc = tif.cmd_pix_cnt;
    c.kb = tif.cmd_k_base;
    c.kc = tif.cmd_k_cnt;
    c.db = tif.cmd_d_base;
    c.dc = tif.cmd_d_cnt;
    c.fd = tif.cmd_first_d;
    c.ld = tif.cmd_last_d;
    return c;
  endfunction

  // All outputs as one vector, for reset/idle checks.
  function automatic logic [127:0] all_outs();
    return {obs_cmd(), tif.cmd_valid, busy, done, err};
  endfunction

  task automatic model(input int tp, input int tn, input int ic, input int oc,
                       input int td, input int tk);
    cmd_t c;
    if (tn == 0 || td == 0 || tk == 0 || tp == 0 || ic == 0 || oc == 0) return;
    for (int p = 0; p < tp; p += tn)
      for (int k = 0; k < oc; k += tk)
        for (int d = 0; d < ic; d += td) begin
          c.pb = PIX_W'(p);
          c.pc = PIX_W'((tp - p < tn) ? tp - p : tn);
          c.kb = CH_W'(k);
          c.kc = CH_W'((oc - k < tk) ? oc - k : tk);
          c.db = CH_W'(d);
          c.dc = CH_W'((ic - d < td) ? ic - d : td);
          c.fd = (d == 0);
          c.ld = (d + td >= ic);
          sb.push_back(c);
        end
  endtask

  task automatic start_layer(input int tp, input int tn, input int ic, input int oc,
                             input int td, input int tk);
    total_pix = PIX_W'(tp);
    tile_n    = PIX_W'(tn);
    in_c      = CH_W'(ic);
    out_c     = CH_W'(oc);
    tile_d    = CH_W'(td);
    tile_k    = CH_W'(tk);
    start     = 1'b1;
    model(tp, tn, ic, oc, td, tk);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("no_valid_t1", tif.cmd_valid, 1'b0);
  endtask

  // Serve one command: optional backpressure, handshake, idle WAIT cycles, then tile_done.
  task automatic serve(input int hold, input int wcyc, input bit spur, input bit done_hs);
    cmd_t exp;
    int   n = 0;
    while (!tif.cmd_valid && n < 20) begin
      step();
      n++;
    end
    chk("cmd_valid_seen", tif.cmd_valid, 1'b1);
    chk("sb_nonempty", sb.size() > 0, 1'b1);
    if (sb.size() == 0) return;
    exp = sb.pop_front();
    chk("cmd_fields", obs_cmd(), exp);
    for (int i = 0; i < hold; i++) begin
      tif.cmd_ready = 1'b0;
      tif.tile_done = spur;
      step();
      tif.tile_done = 1'b0;
      chk("hold_valid", tif.cmd_valid, 1'b1);
      chk("hold_fields", obs_cmd(), exp);
    end
    tif.cmd_ready = 1'b1;
    tif.tile_done = done_hs;
    step();
    tif.cmd_ready = 1'b0;
    tif.tile_done = 1'b0;
    for (int i = 0; i < wcyc; i++) begin
      chk("wait_no_cmd", tif.cmd_valid, 1'b0);
      step();
    end
    tif.tile_done = 1'b1;
    step();
    tif.tile_done = 1'b0;
    chk("next_valid_t1", tif.cmd_valid, sb.size() != 0);
    chk("done_at_end", done, sb.size() == 0);
  endtask

  initial begin
    tif.cmd_ready = 1'b0;
    tif.tile_done = 1'b0;

    // Reset state
    step();
    step();
    chk("reset_outputs", all_outs(), '0);
    rst_n = 1'b1;
    step();
    chk("idle_outputs", all_outs(), '0);

    // Basic walk of 12 tiles; backpressure and no early second command on cmd0
    start_layer(10, 4, 5, 3, 4, 2);
    step();
    chk("valid_t2", tif.cmd_valid, 1'b1);
    chk("sb_count_l1", sb.size(), 12);
    serve(5, 3, 1'b0, 1'b0);
    while (sb.size() > 0) serve(0, 1, 1'b0, 1'b0);
    chk("done_busy_fin", busy, 1'b1);
    step();
    chk("after_done", {done, busy, err, tif.cmd_valid}, 4'b0000);

    // tile_n == 0: err and done three cycles after start
    start_layer(10, 0, 5, 3, 4, 2);
    step();
    chk("err_path_no_valid", {tif.cmd_valid, done, err}, 3'b000);
    step();
    chk("err_path_fin", {tif.cmd_valid, done, err, busy}, 4'b0111);
    step();
    chk("err_sticky", {done, err, busy}, 3'b010);

    // total_pix == 0: done without err; start while busy is ignored; err clears
    start_layer(0, 4, 5, 3, 4, 2);
    chk("err_cleared", err, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_done", {tif.cmd_valid, done, err}, 3'b010);
    step();
    chk("empty_idle", {done, busy}, 2'b00);
    step();
    chk("restart_ignored", {busy, tif.cmd_valid}, 2'b00);

    // Reset while in WAIT aborts to idle with no done pulse
    start_layer(10, 4, 5, 3, 4, 2);
    step();
    tif.cmd_ready = 1'b1;
    step();
    tif.cmd_ready = 1'b0;
    chk("in_wait", {tif.cmd_valid, busy}, 2'b01);
    rst_n = 1'b0;
    step();
    chk("abort_outputs", all_outs(), '0);
    rst_n = 1'b1;
    sb.delete();
    step();
    chk("abort_idle", all_outs(), '0);

    // Exact fit; spurious tile_done in ISSUE and in the handshake cycle are ignored
    start_layer(8, 4, 16, 16, 16, 16);
    step();
    chk("sb_count_fit", sb.size(), 2);
    serve(2, 2, 1'b1, 1'b1);
    serve(0, 1, 1'b0, 1'b0);
    step();
    chk("fit_after_done", {done, busy, err}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
